// File: rtl/token_decoder.sv
// Token decoder: walks a zero-terminated code stream, expands each code through a
// fixed-stride vocab RAM and writes a zero-terminated byte string to an output RAM.
module token_decoder #(
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ENTRY_LOG2 = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cs,
   output logic [ADDR_WIDTH-1:0] code_addr,
   input  logic [DATA_WIDTH-1:0] code_dout,
   output logic [ADDR_WIDTH-1:0] vocab_addr,
   input  logic [DATA_WIDTH-1:0] vocab_dout,
   output logic [ADDR_WIDTH-1:0] out_addr,
   output logic [DATA_WIDTH-1:0] out_din,
   output logic                  out_we,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [ADDR_WIDTH-1:0] char_count
);

   localparam int unsigned ENTRY_LEN = 1 << ENTRY_LOG2;
   localparam int unsigned CODE_BITS = ADDR_WIDTH - ENTRY_LOG2;
   localparam int unsigned K_W       = (ENTRY_LOG2 > 0) ? ENTRY_LOG2 : 1;
   localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;
   localparam logic [K_W-1:0]        K_LAST   = K_W'(ENTRY_LEN - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_FETCH_CODE, S_CHECK_CODE, S_FETCH_CHAR, S_CHECK_CHAR,
      S_EMIT, S_NEXT_CODE, S_TERM, S_DONE, S_ERROR
   } state_e;

   state_e state_q, state_d;

   logic [ADDR_WIDTH-1:0] code_addr_q,  code_addr_d;
   logic [ADDR_WIDTH-1:0] vocab_addr_q, vocab_addr_d;
   logic [ADDR_WIDTH-1:0] out_addr_q,   out_addr_d;
   logic [DATA_WIDTH-1:0] out_din_q,    out_din_d;
   logic [ADDR_WIDTH-1:0] char_count_q, char_count_d;
   logic [K_W-1:0]        k_q,          k_d;
   logic                  out_we_q, out_we_d;
   logic                  busy_q,   busy_d;
   logic                  done_q,   done_d;
   logic                  error_q,  error_d;

   logic code_oob_c;
   logic char_full_c;
   logic k_last_c;
   logic code_last_c;

   // Any bit above the vocab index range marks a code with no entry.
   assign code_oob_c  = (code_dout >> CODE_BITS) != '0;
   assign char_full_c = (char_count_q == ADDR_MAX);
   assign k_last_c    = (k_q == K_LAST);
   assign code_last_c = (code_addr_q == ADDR_MAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:       if (cs) state_d = S_FETCH_CODE;
         S_FETCH_CODE: state_d = S_CHECK_CODE;
         S_CHECK_CODE: begin
            if (code_dout == '0)  state_d = S_TERM;
            else if (code_oob_c)  state_d = S_ERROR;
            else                  state_d = S_FETCH_CHAR;
         end
         S_FETCH_CHAR: state_d = S_CHECK_CHAR;
         S_CHECK_CHAR: begin
            if (vocab_dout == '0) state_d = S_NEXT_CODE;
            else if (char_full_c) state_d = S_ERROR;
            else                  state_d = S_EMIT;
         end
         S_EMIT:       state_d = k_last_c ? S_NEXT_CODE : S_FETCH_CHAR;
         S_NEXT_CODE:  state_d = code_last_c ? S_TERM : S_FETCH_CODE;
         S_TERM:       state_d = S_DONE;
         S_DONE:       state_d = S_DONE;
         S_ERROR:      state_d = S_ERROR;
         default:      state_d = S_IDLE;
      endcase
   end

   // Datapath and flag next values; flags follow the state being entered.
   always_comb begin
      code_addr_d  = code_addr_q;
      vocab_addr_d = vocab_addr_q;
      out_addr_d   = out_addr_q;
      out_din_d    = out_din_q;
      char_count_d = char_count_q;
      k_d          = k_q;
      out_we_d     = (state_d == S_EMIT) || (state_d == S_TERM);
      busy_d       = !((state_d == S_IDLE) || (state_d == S_DONE) || (state_d == S_ERROR));
      done_d       = (state_d == S_DONE);
      error_d      = (state_d == S_ERROR);

      unique case (state_q)
         S_IDLE: begin
            if (cs) begin
               code_addr_d  = '0;
               out_addr_d   = '0;
               char_count_d = '0;
            end
         end
         S_CHECK_CODE: begin
            if (state_d == S_FETCH_CHAR) begin
               vocab_addr_d = ADDR_WIDTH'(code_dout) << ENTRY_LOG2;
               k_d          = '0;
            end
         end
         S_CHECK_CHAR: begin
            if (state_d == S_EMIT) out_din_d = vocab_dout;
         end
         S_EMIT: begin
            out_addr_d   = out_addr_q + 1'b1;
            char_count_d = char_count_q + 1'b1;
            if (!k_last_c) begin
               k_d          = k_q + 1'b1;
               vocab_addr_d = vocab_addr_q + 1'b1;
            end
         end
         S_NEXT_CODE: begin
            if (!code_last_c) code_addr_d = code_addr_q + 1'b1;
         end
         default: ;
      endcase

      if (state_d == S_TERM) out_din_d = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         code_addr_q  <= '0;
         vocab_addr_q <= '0;
         out_addr_q   <= '0;
         out_din_q    <= '0;
         char_count_q <= '0;
         k_q          <= '0;
         out_we_q     <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         code_addr_q  <= code_addr_d;
         vocab_addr_q <= vocab_addr_d;
         out_addr_q   <= out_addr_d;
         out_din_q    <= out_din_d;
         char_count_q <= char_count_d;
         k_q          <= k_d;
         out_we_q     <= out_we_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         error_q      <= error_d;
      end
   end

   assign code_addr  = code_addr_q;
   assign vocab_addr = vocab_addr_q;
   assign out_addr   = out_addr_q;
   assign out_din    = out_din_q;
   assign out_we     = out_we_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign error      = error_q;
   assign char_count = char_count_q;

endmodule

// File: doc/token_decoder.md
Name: token_decoder

Overview:
- Downstream consumer of the tokenizer encoder's output code RAM.
- Reads a zero-terminated stream of token codes and looks each code up in a fixed-stride vocab RAM.
- Writes the expanded characters as a zero-terminated byte string into an output RAM, which lets the bench round-trip encode/decode.
- All three memories are external single-port srams with 1-cycle registered read latency; this block only drives their addresses and write strobes.

Parameters:
ADDR_WIDTH, 4, address width of code, vocab and output RAMs
DATA_WIDTH, 8, width of codes and characters
ENTRY_LOG2, 2, log2 of vocab entry stride in bytes (ENTRY_LEN = 2**ENTRY_LOG2)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
cs  in  1  start; sampled only in IDLE
code_addr  out  ADDR_WIDTH  code RAM read address
code_dout  in  DATA_WIDTH  code RAM data, valid 1 cycle after code_addr
vocab_addr  out  ADDR_WIDTH  vocab RAM read address
vocab_dout  in  DATA_WIDTH  vocab RAM data, valid 1 cycle after vocab_addr
out_addr  out  ADDR_WIDTH  output RAM write address
out_din  out  DATA_WIDTH  output RAM write data
out_we  out  1  output RAM write strobe, one cycle per byte
busy  out  1  high from start until DONE/ERROR
done  out  1  sticky high in DONE
error  out  1  sticky high in ERROR
char_count  out  ADDR_WIDTH  characters written, terminator excluded

Behaviour:
- Reset: all outputs and address registers 0; state IDLE.
- Vocab layout:
  - Entry for code c starts at address c<<ENTRY_LOG2, holding up to ENTRY_LEN bytes, zero-padded.
  - Code 0 is the stream terminator; entry 0 is unused.
  - Valid codes: 1 .. 2**(ADDR_WIDTH-ENTRY_LOG2)-1.
- States and transitions:
  - IDLE: cs=1 -> FETCH_CODE, with busy=1, code_addr=0, out_addr=0, char_count=0.
  - FETCH_CODE: wait one cycle for code_dout -> CHECK_CODE.
  - CHECK_CODE:
    - code_dout==0 -> TERM.
    - code_dout >= 2**(ADDR_WIDTH-ENTRY_LOG2) -> ERROR.
    - Otherwise: vocab_addr = code_dout<<ENTRY_LOG2, byte index k=0 -> FETCH_CHAR.
  - FETCH_CHAR: wait one cycle -> CHECK_CHAR.
  - CHECK_CHAR:
    - vocab_dout==0 -> NEXT_CODE.
    - Else, if char_count == 2**ADDR_WIDTH-1 (last slot is reserved for the terminator) -> ERROR.
    - Else -> EMIT, registering out_din=vocab_dout.
  - EMIT:
    - out_we=1 for exactly this cycle; out_addr holds the write address.
    - Next cycle: out_addr+1, char_count+1.
    - k==ENTRY_LEN-1 -> NEXT_CODE; else k+1, vocab_addr+1 -> FETCH_CHAR.
  - NEXT_CODE:
    - code_addr == 2**ADDR_WIDTH-1 -> TERM (no wrap past the code RAM end).
    - Else code_addr+1 -> FETCH_CODE.
  - TERM: out_we=1 with out_din=0 at out_addr -> DONE.
  - DONE: done=1, busy=0; holds until reset, cs ignored.
  - ERROR: error=1, busy=0, no further writes; holds until reset.
- Per-code cost: 2 cycles (fetch/check) + 3 cycles per emitted char + 2 cycles for the final FETCH/CHECK of an entry that ends early + 1 (NEXT_CODE).
- out_we is never high outside EMIT/TERM; out_addr/out_din are stable while out_we=1.
- char_count saturates by construction (never exceeds 2**ADDR_WIDTH-1).
- Reset asserted mid-operation:
  - Immediately returns to IDLE and clears all outputs.
  - A partially written output RAM is left as is.
- Widths: address arithmetic is modulo 2**ADDR_WIDTH; the code is truncated to ADDR_WIDTH before the shift only after the range check has passed.

Test Plan:
- Vocab entry1="ab\0\0", entry2="cde\0", codes [1,2,0]; pulse cs -> output "abcde\0" at addr 0..5, char_count=5, done=1, error=0, exactly 6 out_we pulses.
- Full-length entry3="wxyz", codes [3,3,0] -> output "wxyzwxyz\0", char_count=8; no vocab read beyond byte 3 of entry 3.
- Codes [0] -> single write of 0 at addr 0, char_count=0, done=1 within 4 cycles of cs.
- Codes [1,4,0] with ADDR_WIDTH=4 -> "ab" written, then error=1, done=0, no terminator written, busy=0.
- Codes [3,3,3,3,0] -> 15 chars written, 16th char attempt -> error=1, out_addr 15 never written.
- Codes [1,2,...] then rst_n low during EMIT -> all outputs 0 within the same cycle; re-pulse cs with [2,0] -> "cde\0", done=1.
